// File: rtl/branch_decode_unit.sv
// rtl/branch_decode_unit.sv - RV32I decode stage: immediate, ALU op, branch resolve, redirect
// Optional illegal-instruction flag: define BRANCH_DECODE_ILLEGAL_DETECT_EN to add o_illegal.
module branch_decode_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  input  logic        i_ce,
  input  logic        i_stall,
  output logic [31:0] o_imm,
  output logic [3:0]  o_alu_ctrl,
  output logic [6:0]  o_opcode,
  output logic [2:0]  o_func3,
  output logic [4:0]  o_rd,
  output logic        o_ce,
  output logic        o_flush,
  output logic [31:0] o_branch_pc
`ifdef BRANCH_DECODE_ILLEGAL_DETECT_EN
  ,
  output logic        o_illegal
`endif
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_SLL   = 4'b0010;
  localparam logic [3:0] ALU_SLT   = 4'b0011;
  localparam logic [3:0] ALU_SLTU  = 4'b0100;
  localparam logic [3:0] ALU_XOR   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_OR    = 4'b1000;
  localparam logic [3:0] ALU_AND   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        alt;
  logic [31:0] imm;
  logic [3:0]  alu_ctrl;
  logic        br_taken;
  logic        update;

  assign opcode = i_instr[6:0];
  assign func3  = i_instr[14:12];
  assign alt    = i_instr[30];
  assign update = i_ce & ~i_stall;

  // Immediate extraction per instruction format
  always_comb begin
    imm = 32'd0;
    case (opcode)
      OP_I, OP_LOAD, OP_JALR: imm = {{20{i_instr[31]}}, i_instr[31:20]};
      OP_STORE:               imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      OP_BRANCH:              imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                     i_instr[30:25], i_instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:       imm = {i_instr[31:12], 12'h000};
      OP_JAL:                 imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                     i_instr[20], i_instr[30:21], 1'b0};
      default:                imm = 32'd0;
    endcase
  end

  // ALU operation select; only R-type honours instr[30] on func3 000
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (opcode)
      OP_R, OP_I: begin
        case (func3)
          3'b000:  alu_ctrl = (opcode == OP_R && alt) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b011:  alu_ctrl = ALU_SLTU;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = alt ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
      OP_LUI:  alu_ctrl = ALU_PASSB;
      default: alu_ctrl = ALU_ADD;
    endcase
  end

  // Branch condition evaluation on the raw register-file operands
  always_comb begin
    br_taken = 1'b0;
    if (opcode == OP_BRANCH) begin
      case (func3)
        3'b000:  br_taken = (i_rs1_data == i_rs2_data);
        3'b001:  br_taken = (i_rs1_data != i_rs2_data);
        3'b100:  br_taken = ($signed(i_rs1_data) <  $signed(i_rs2_data));
        3'b101:  br_taken = ($signed(i_rs1_data) >= $signed(i_rs2_data));
        3'b110:  br_taken = (i_rs1_data <  i_rs2_data);
        3'b111:  br_taken = (i_rs1_data >= i_rs2_data);
        default: br_taken = 1'b0;
      endcase
    end
  end

  // Redirect target; JALR clears bit 0 of the computed address
  always_comb begin
    o_branch_pc = 32'd0;
    case (opcode)
      OP_BRANCH, OP_JAL: o_branch_pc = i_pc + imm;
      OP_JALR:           o_branch_pc = (i_rs1_data + imm) & ~32'd1;
      default:           o_branch_pc = 32'd0;
    endcase
  end

  // Redirect is resolved in the same cycle and ignores downstream stall
  assign o_flush = i_ce & ~rst & ((opcode == OP_JAL) | (opcode == OP_JALR) | br_taken);

  // Pipeline register toward execute; stall holds payload and drops valid
  always_ff @(posedge clk) begin
    if (rst) begin
      o_imm      <= 32'd0;
      o_alu_ctrl <= 4'd0;
      o_opcode   <= 7'd0;
      o_func3    <= 3'd0;
      o_rd       <= 5'd0;
      o_ce       <= 1'b0;
    end else begin
      if (update) begin
        o_imm      <= imm;
        o_alu_ctrl <= alu_ctrl;
        o_opcode   <= opcode;
        o_func3    <= func3;
        o_rd       <= i_instr[11:7];
      end
      o_ce <= i_stall ? 1'b0 : i_ce;
    end
  end

`ifdef BRANCH_DECODE_ILLEGAL_DETECT_EN
  logic illegal;

  // Unknown opcodes and R-type encodings with a bad funct7 are illegal
  always_comb begin
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        if (i_instr[31:25] != 7'b0000000 && i_instr[31:25] != 7'b0100000)
          illegal = 1'b1;
        else if (i_instr[31:25] == 7'b0100000 && func3 != 3'b000 && func3 != 3'b101)
          illegal = 1'b1;
      end
      OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: illegal = 1'b0;
      default: illegal = 1'b1;
    endcase
  end

  // Illegal flag travels with the opcode register
  always_ff @(posedge clk) begin
    if (rst)
      o_illegal <= 1'b0;
    else if (update)
      o_illegal <= illegal;
  end
`endif

endmodule

// File: tb/tb_branch_decode_unit.sv
// tb/tb_branch_decode_unit.sv - randomized self-checking bench for branch_decode_unit
module tb_branch_decode_unit;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_instr, i_pc, i_rs1_data, i_rs2_data;
  logic        i_ce, i_stall;
  logic [31:0] o_imm, o_branch_pc;
  logic [3:0]  o_alu_ctrl;
  logic [6:0]  o_opcode;
  logic [2:0]  o_func3;
  logic [4:0]  o_rd;
  logic        o_ce, o_flush;
`ifdef BRANCH_DECODE_ILLEGAL_DETECT_EN
  logic        o_illegal;
  logic        exp_illegal;
`endif

  always #5 clk = ~clk;

  branch_decode_unit dut (
    .clk(clk), .rst(rst), .i_instr(i_instr), .i_pc(i_pc),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
    .i_ce(i_ce), .i_stall(i_stall),
    .o_imm(o_imm), .o_alu_ctrl(o_alu_ctrl), .o_opcode(o_opcode),
    .o_func3(o_func3), .o_rd(o_rd), .o_ce(o_ce),
    .o_flush(o_flush), .o_branch_pc(o_branch_pc)
`ifdef BRANCH_DECODE_ILLEGAL_DETECT_EN
    , .o_illegal(o_illegal)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_imm;
  logic [3:0]  exp_alu;
  logic [6:0]  exp_opcode;
  logic [2:0]  exp_func3;
  logic [4:0]  exp_rd;
  logic        exp_ce;
  logic        last_flush;
  logic [31:0] last_bpc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Immediate built arithmetically from bit weights rather than by concatenation
  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    logic [31:0] r;
    r = 32'd0;
    case (ins[6:0])
      OP_I, OP_LOAD, OP_JALR: r = 32'($signed(ins) >>> 20);
      OP_STORE:  r = (32'($signed(ins) >>> 25) << 5) | 32'(ins[11:7]);
      OP_BRANCH: r = 32'(ins[11:8]) * 2 + 32'(ins[30:25]) * 32 + 32'(ins[7]) * 2048
                     - 32'(ins[31]) * 4096;
      OP_JAL:    r = 32'(ins[30:21]) * 2 + 32'(ins[20]) * 2048 + 32'(ins[19:12]) * 4096
                     - 32'(ins[31]) * 32'h0010_0000;
      OP_LUI, OP_AUIPC: r = ins & 32'hFFFF_F000;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] ref_alu(input logic [31:0] ins);
    logic [3:0] base;
    if (ins[6:0] == OP_LUI) return 4'b1010;
    if (ins[6:0] != OP_R && ins[6:0] != OP_I) return 4'b0000;
    case (ins[14:12])
      3'd0: base = (ins[6:0] == OP_R && ins[30]) ? 4'd1 : 4'd0;
      3'd1: base = 4'd2;
      3'd2: base = 4'd3;
      3'd3: base = 4'd4;
      3'd4: base = 4'd5;
      3'd5: base = ins[30] ? 4'd7 : 4'd6;
      3'd6: base = 4'd8;
      default: base = 4'd9;
    endcase
    return base;
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

`ifdef BRANCH_DECODE_ILLEGAL_DETECT_EN
  function automatic logic ref_illegal(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    if (op == OP_R)
      return !((ins[31:25] == 7'h00) ||
               (ins[31:25] == 7'h20 && (ins[14:12] == 3'd0 || ins[14:12] == 3'd5)));
    return !(op inside {OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC});
  endfunction
`endif

  // One clock: drive at negedge, check combinational redirect, then registered outputs
  task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] a,
                      input logic [31:0] b, input logic ce, input logic st, input logic r,
                      input string tag);
    logic [31:0] imm, tgt;
    logic        fl, jump;
    @(negedge clk);
    i_instr = ins; i_pc = pc; i_rs1_data = a; i_rs2_data = b;
    i_ce = ce; i_stall = st; rst = r;
    #1;
    imm  = ref_imm(ins);
    jump = (ins[6:0] == OP_JAL) || (ins[6:0] == OP_JALR);
    if (ins[6:0] == OP_BRANCH || ins[6:0] == OP_JAL) tgt = pc + imm;
    else if (ins[6:0] == OP_JALR) tgt = (a + imm) & 32'hFFFF_FFFE;
    else tgt = 32'd0;
    fl = ce && !r && (jump || (ins[6:0] == OP_BRANCH && ref_taken(ins[14:12], a, b)));
    last_flush = o_flush;
    last_bpc   = o_branch_pc;
    check_eq({tag, ".flush"}, 32'(o_flush), 32'(fl));
    check_eq({tag, ".branch_pc"}, o_branch_pc, tgt);
    if (r) begin
      exp_imm = 0; exp_alu = 0; exp_opcode = 0; exp_func3 = 0; exp_rd = 0; exp_ce = 0;
`ifdef BRANCH_DECODE_ILLEGAL_DETECT_EN
      exp_illegal = 0;
`endif
    end else begin
      if (ce && !st) begin
        exp_imm = imm; exp_alu = ref_alu(ins); exp_opcode = ins[6:0];
        exp_func3 = ins[14:12]; exp_rd = ins[11:7];
`ifdef BRANCH_DECODE_ILLEGAL_DETECT_EN
        exp_illegal = ref_illegal(ins);
`endif
      end
      exp_ce = st ? 1'b0 : ce;
    end
    @(posedge clk);
    #1;
    check_eq({tag, ".imm"}, o_imm, exp_imm);
    check_eq({tag, ".alu"}, 32'(o_alu_ctrl), 32'(exp_alu));
    check_eq({tag, ".opcode"}, 32'(o_opcode), 32'(exp_opcode));
    check_eq({tag, ".func3"}, 32'(o_func3), 32'(exp_func3));
    check_eq({tag, ".rd"}, 32'(o_rd), 32'(exp_rd));
    check_eq({tag, ".ce"}, 32'(o_ce), 32'(exp_ce));
`ifdef BRANCH_DECODE_ILLEGAL_DETECT_EN
    check_eq({tag, ".illegal"}, 32'(o_illegal), 32'(exp_illegal));
`endif
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  ops [9];
    int          sel, f7;
    ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    ins = $urandom;
    sel = $urandom_range(0, 10);
    if (sel < 9) ins[6:0] = ops[sel];
    if (ins[6:0] == OP_R) begin
      f7 = $urandom_range(0, 3);
      if (f7 == 0) ins[31:25] = 7'h00;
      else if (f7 == 1) ins[31:25] = 7'h20;
    end
    return ins;
  endfunction

  initial begin
    logic [31:0] ins, a, b;
    rst = 1'b1; i_instr = 0; i_pc = 0; i_rs1_data = 0; i_rs2_data = 0; i_ce = 0; i_stall = 0;
    exp_imm = 0; exp_alu = 0; exp_opcode = 0; exp_func3 = 0; exp_rd = 0; exp_ce = 0;
    last_flush = 0; last_bpc = 0;
`ifdef BRANCH_DECODE_ILLEGAL_DETECT_EN
    exp_illegal = 0;
`endif
    step(32'h00500093, 0, 0, 0, 1, 0, 1, "reset0");
    step(32'h00500093, 0, 0, 0, 1, 1, 1, "reset1");
    check_eq("reset.ce", 32'(o_ce), 0);

    step(32'h00500093, 0, 0, 0, 1, 0, 0, "addi");
    check_eq("addi.imm_const", o_imm, 32'd5);
    check_eq("addi.rd_const", 32'(o_rd), 32'd1);
    step(32'h40208033, 0, 0, 0, 1, 0, 0, "sub");
    check_eq("sub.alu_const", 32'(o_alu_ctrl), 32'd1);
    step(32'h12345037, 0, 0, 0, 1, 0, 0, "lui");
    check_eq("lui.imm_const", o_imm, 32'h12345000);
    check_eq("lui.alu_const", 32'(o_alu_ctrl), 32'd10);
    step(32'h00208463, 32'h100, 5, 5, 1, 0, 0, "beq_t");
    check_eq("beq_t.flush_const", 32'(last_flush), 1);
    check_eq("beq_t.pc_const", last_bpc, 32'h108);
    step(32'h00208463, 32'h100, 5, 6, 1, 0, 0, "beq_nt");
    check_eq("beq_nt.flush_const", 32'(last_flush), 0);
    step(32'h0020c463, 32'h100, 32'hFFFF_FFFF, 1, 1, 0, 0, "blt");
    check_eq("blt.flush_const", 32'(last_flush), 1);
    step(32'h0020e463, 32'h100, 32'hFFFF_FFFF, 1, 1, 0, 0, "bltu");
    check_eq("bltu.flush_const", 32'(last_flush), 0);
    step(32'h004080e7, 0, 32'h1003, 0, 1, 0, 0, "jalr");
    check_eq("jalr.pc_const", last_bpc, 32'h1006);
    step(32'hFFDFF06F, 32'h200, 0, 0, 1, 0, 0, "jal");
    check_eq("jal.pc_const", last_bpc, 32'h1FC);
    check_eq("jal.imm_const", o_imm, 32'hFFFF_FFFC);
    step(32'h00500093, 0, 0, 0, 1, 0, 0, "pre_stall");
    step(32'h12345037, 0, 0, 0, 1, 1, 0, "stall0");
    step(32'h40208033, 0, 0, 0, 1, 1, 0, "stall1");
    check_eq("stall.imm_hold", o_imm, 32'd5);
    check_eq("stall.ce_low", 32'(o_ce), 0);
    step(32'h004080e7, 0, 32'h1003, 0, 1, 1, 0, "jalr_stall");
    check_eq("jalr_stall.flush_const", 32'(last_flush), 1);
    step(32'h12345037, 0, 0, 0, 1, 0, 1, "mid_rst");
    check_eq("mid_rst.imm_const", o_imm, 0);
    check_eq("mid_rst.alu_const", 32'(o_alu_ctrl), 0);

    for (int i = 0; i < 500; i++) begin
      ins = rand_instr();
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      step(ins, $urandom, a, b, ($urandom_range(0, 9) < 8), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 39) == 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/branch_decode_unit.md
BRANCH_DECODE_UNIT -- requirements
Module: branch_decode_unit

Interface
REQ-001 SHALL have no parameters; widths are fixed at RV32I (XLEN 32).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 i_instr  input  32  instruction to decode.
REQ-005 i_pc  input  32  PC of i_instr.
REQ-006 i_rs1_data  input  32  register-file read data for rs1.
REQ-007 i_rs2_data  input  32  register-file read data for rs2.
REQ-008 i_ce  input  1  input instruction valid / stage enable.
REQ-009 i_stall  input  1  downstream stall.
REQ-010 o_imm  output  32  registered sign-extended immediate.
REQ-011 o_alu_ctrl  output  4  registered ALU operation.
REQ-012 o_opcode / o_func3 / o_rd  output  7/3/5  registered instr[6:0] / [14:12] / [11:7].
REQ-013 o_ce  output  1  registered valid to next stage.
REQ-014 o_flush  output  1  combinational redirect request (branch taken or jump).
REQ-015 o_branch_pc  output  32  combinational redirect target.

Function
REQ-016 Opcodes SHALL be: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
REQ-017 Immediates: I/LOAD/JALR sext(instr[31:20]); STORE sext({[31:25],[11:7]}); BRANCH sext({[31],[7],[30:25],[11:8],0}); LUI/AUIPC {[31:12],12'h000}; JAL sext({[31],[19:12],[20],[30:21],0}); any other opcode 0.
REQ-018 ALU codes: ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001, PASSB 1010.
REQ-019 R-type: func3 selects op; func3 000 with instr[30]=1 -> SUB; 101 with instr[30]=1 -> SRA.
REQ-020 I-type: as R-type except func3 000 always ADD; 101 uses instr[30] for SRL/SRA.
REQ-021 LOAD, STORE, BRANCH, JAL, JALR, AUIPC -> ADD; LUI -> PASSB; any other opcode -> ADD.
REQ-022 BRANCH taken: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; func3 010/011 never taken.
REQ-023 o_branch_pc: BRANCH/JAL = i_pc + imm (mod 2^32); JALR = (i_rs1_data + imm) & ~1; other opcodes 0.
REQ-024 o_flush = i_ce & ~rst & (JAL | JALR | BRANCH taken); same cycle as input, no latency.
REQ-025 Registered outputs update on clk when i_ce=1 and i_stall=0 (1-cycle latency); otherwise hold.
REQ-026 o_ce <= 0 when i_stall=1, else <= i_ce.
REQ-027 o_flush is not gated by i_stall.

Reset
REQ-028 When rst=1 at a clk edge, o_imm, o_alu_ctrl, o_opcode, o_func3, o_rd, o_ce SHALL become 0, overriding i_ce/i_stall.
REQ-029 Combinational o_flush SHALL be 0 while rst=1; o_branch_pc is not reset.

Configuration
REQ-030 Macro BRANCH_DECODE_ILLEGAL_DETECT_EN: when defined, adds output o_illegal (1 bit, registered like o_opcode, reset 0), set for opcodes outside REQ-016 or R-type with instr[31:25] not 0000000/0100000 or invalid instr[30] use; when undefined, the port does not exist and decode is otherwise identical.

Verification
REQ-031 i_instr=0x00500093 (ADDI x1,x0,5), i_ce=1 -> next cycle o_imm=5, o_alu_ctrl=0000, o_rd=1, o_ce=1, o_flush=0.
REQ-032 i_instr=0x40208033 (SUB) -> o_alu_ctrl=0001; i_instr=0x12345037 (LUI) -> o_imm=0x12345000, o_alu_ctrl=1010.
REQ-033 BEQ imm=8 (0x00208463), i_pc=0x100, rs1=rs2=5 -> o_flush=1, o_branch_pc=0x108 same cycle; rs2=6 -> o_flush=0.
REQ-034 BLT vs BLTU with rs1=0xFFFFFFFF, rs2=1 -> BLT taken, BLTU not taken.
REQ-035 JALR imm=4, rs1=0x1003 -> o_branch_pc=0x1006, o_flush=1; JAL imm=-4 at pc 0x200 -> 0x1FC.
REQ-036 Stall: i_stall=1 for 2 cycles with new i_instr -> registered outputs hold, o_ce=0; rst=1 mid-stream -> all registered outputs 0 next edge.
